seq_triangle_checker: RTL and testbench

//  Receiving end of the 4-bit up/down "triangle" sequence stream (0,1,..,MAX,MAX-1,..,0,1,..).

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_expect.sv | 32 +++
 rtl/seq_triangle_checker.sv | 168 ++++++++++++++++
 tb/tb_seq_triangle_checker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the triangle sequence link
// State encoding and direction constants used by the checker and its expect helper.
package seq_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

endpackage

// File: rtl/seq_expect.sv
// rtl/seq_expect.sv - next value of the up/down triangle sequence
// Pure combinational; the generator uses the same rule, so both ends agree on the turnarounds.
module seq_expect
  import seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic             i_dir,
  output logic [WIDTH-1:0] o_expected,
  output logic             o_next_dir
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  // The endpoints force the direction; there is no wrap between MAX and 0.
  always_comb begin
    o_expected = i_prev + 1'b1;
    o_next_dir = UP;
    if (i_prev == MAX_VAL) begin
      o_expected = MAX_VAL - 1'b1;
      o_next_dir = DOWN;
    end else if (i_prev == '0) begin
      o_expected = i_prev + 1'b1;
      o_next_dir = UP;
    end else if (i_dir == DOWN) begin
      o_expected = i_prev - 1'b1;
      o_next_dir = DOWN;
    end
  end

endmodule

// File: rtl/seq_triangle_checker.sv
// rtl/seq_triangle_checker.sv - lock-and-track monitor for the triangle sequence stream
// Acquires the pattern, follows its direction and counts every deviation seen while locked.
module seq_triangle_checker
  import seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     sequencia_in,
  input  logic                 clr_count,
  output logic                 locked,
  output logic                 sentido,
  output logic                 erro,
  output logic                 peak_pulse,
  output logic                 valley_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int                   CNT_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]     MAX_VAL  = '1;
  localparam logic [CNT_W-1:0]     LOCK_THR = CNT_W'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ERR_SAT  = '1;

  state_t               r_state, w_state;
  logic [WIDTH-1:0]     r_prev, w_prev;
  logic                 r_dir, w_dir;
  logic                 r_dir_known, w_dir_known;
  logic [CNT_W-1:0]     r_match_cnt, w_match_cnt;
  logic                 r_locked, w_locked;
  logic                 r_sentido, w_sentido;
  logic                 r_erro, w_erro;
  logic                 r_peak, w_peak;
  logic                 r_valley, w_valley;
  logic [ERR_CNT_W-1:0] r_err_count, w_err_count;

  logic [WIDTH-1:0]     w_expected;
  logic                 w_exp_dir;
  logic [WIDTH-1:0]     w_prev_inc;
  logic [WIDTH-1:0]     w_prev_dec;

  assign w_prev_inc = r_prev + 1'b1;
  assign w_prev_dec = r_prev - 1'b1;

  seq_expect #(.WIDTH(WIDTH)) u_expect (
    .i_prev     (r_prev),
    .i_dir      (r_dir),
    .o_expected (w_expected),
    .o_next_dir (w_exp_dir)
  );

  always_comb begin
    w_state     = r_state;
    w_prev      = r_prev;
    w_dir       = r_dir;
    w_dir_known = r_dir_known;
    w_match_cnt = r_match_cnt;
    w_locked    = r_locked;
    w_sentido   = r_sentido;
    w_erro      = 1'b0;
    w_peak      = 1'b0;
    w_valley    = 1'b0;

    if (valid) begin
      case (r_state)
        SEARCH: begin
          w_prev      = sequencia_in;
          w_dir_known = 1'b0;
          w_match_cnt = '0;
          w_state     = ACQUIRE;
        end
        ACQUIRE: begin
          w_prev      = sequencia_in;
          w_dir_known = 1'b0;
          w_match_cnt = '0;
          // With no direction yet, any single legal step establishes one.
          if (!r_dir_known) begin
            if (r_prev != MAX_VAL && sequencia_in == w_prev_inc) begin
              w_dir       = UP;
              w_dir_known = 1'b1;
              w_match_cnt = CNT_W'(1);
            end else if (r_prev != '0 && sequencia_in == w_prev_dec) begin
              w_dir       = DOWN;
              w_dir_known = 1'b1;
              w_match_cnt = CNT_W'(1);
            end
          end else if (sequencia_in == w_expected) begin
            w_dir       = w_exp_dir;
            w_dir_known = 1'b1;
            w_match_cnt = r_match_cnt + 1'b1;
          end
          if (w_dir_known && w_match_cnt >= LOCK_THR) begin
            w_state  = LOCKED;
            w_locked = 1'b1;
          end
        end
        LOCKED: begin
          w_prev = sequencia_in;
          if (sequencia_in == w_expected) begin
            w_dir     = w_exp_dir;
            w_sentido = w_exp_dir;
            w_peak    = (sequencia_in == MAX_VAL);
            w_valley  = (sequencia_in == '0);
          end else begin
            w_erro      = 1'b1;
            w_locked    = 1'b0;
            w_state     = ACQUIRE;
            w_dir_known = 1'b0;
            w_match_cnt = '0;
          end
        end
        default: begin
          w_state     = SEARCH;
          w_locked    = 1'b0;
          w_dir_known = 1'b0;
          w_match_cnt = '0;
        end
      endcase
    end

    // A clear in the same cycle as an error still records that error.
    w_err_count = r_err_count;
    if (clr_count) begin
      w_err_count = w_erro ? ERR_CNT_W'(1) : '0;
    end else if (w_erro && r_err_count != ERR_SAT) begin
      w_err_count = r_err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_prev      <= '0;
      r_dir       <= UP;
      r_dir_known <= 1'b0;
      r_match_cnt <= '0;
      r_locked    <= 1'b0;
      r_sentido   <= 1'b0;
      r_erro      <= 1'b0;
      r_peak      <= 1'b0;
      r_valley    <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state;
      r_prev      <= w_prev;
      r_dir       <= w_dir;
      r_dir_known <= w_dir_known;
      r_match_cnt <= w_match_cnt;
      r_locked    <= w_locked;
      r_sentido   <= w_sentido;
      r_erro      <= w_erro;
      r_peak      <= w_peak;
      r_valley    <= w_valley;
      r_err_count <= w_err_count;
    end
  end

  assign locked       = r_locked;
  assign sentido      = r_sentido;
  assign erro         = r_erro;
  assign peak_pulse   = r_peak;
  assign valley_pulse = r_valley;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_seq_triangle_checker.sv
// tb/tb_seq_triangle_checker.sv - scoreboard bench for seq_triangle_checker
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_seq_triangle_checker;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [3:0] seq_in;
  logic       clr;

  logic       locked1, sentido1, erro1, peak1, valley1;
  logic [7:0] cnt1;
  logic       locked2, sentido2, erro2, peak2, valley2;
  logic [1:0] cnt2;

  seq_triangle_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .sequencia_in (seq_in),
    .clr_count    (clr),
    .locked       (locked1),
    .sentido      (sentido1),
    .erro         (erro1),
    .peak_pulse   (peak1),
    .valley_pulse (valley1),
    .err_count    (cnt1)
  );

  seq_triangle_checker #(.WIDTH(4), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .valid        (valid),
    .sequencia_in (seq_in),
    .clr_count    (clr),
    .locked       (locked2),
    .sentido      (sentido2),
    .erro         (erro2),
    .peak_pulse   (peak2),
    .valley_pulse (valley2),
    .err_count    (cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // vector: {L,S,E,P,V (dut), cnt8, L,S,E,P,V (dut2), cnt2}
  logic [19:0] exp_q[$];
  string       name_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [7:0]  e8 = 8'd0;
  logic [1:0]  e2 = 2'd0;

  function automatic logic [19:0] actual_vec();
    return {locked1, sentido1, erro1, peak1, valley1, cnt1,
            locked2, sentido2, erro2, peak2, valley2, cnt2};
  endfunction

  function automatic void check(string nm, logic [19:0] got, logic [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (L S E P V cnt8 | L S E P V cnt2)", nm, got, want);
    end
  endfunction

  function automatic logic [3:0] tri_val(int k);
    int m;
    m = k % 30;
    return (m <= 15) ? 4'(m) : 4'(30 - m);
  endfunction

  task automatic step(input logic v, input logic [3:0] s, input logic c,
                      input logic l, input logic sd, input logic e, input logic p,
                      input logic vl, input string nm);
    valid  = v;
    seq_in = s;
    clr    = c;
    if (c) begin
      e8 = 8'd0;
      e2 = 2'd0;
    end
    if (e) begin
      if (e8 != 8'hFF) e8 = e8 + 8'd1;
      if (e2 != 2'h3)  e2 = e2 + 2'd1;
    end
    exp_q.push_back({l, sd, e, p, vl, e8, l, sd, e, p, vl, e2});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: an expectation pushed before this edge belongs to this edge's response.
  initial begin
    logic [19:0] want;
    string       nm;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        @(negedge clk);
        check(nm, actual_vec(), want);
      end
    end
  end

  initial begin
    #300000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: got timeout required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    seq_in = 4'd0;
    clr    = 1'b0;
    #3;
    check("reset_state", actual_vec(), 20'd0);
    #19;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: clean stream from reset
    for (int k = 0; k < 60; k++) begin
      logic [3:0] t, tp;
      t  = tri_val(k);
      tp = (k > 0) ? tri_val(k - 1) : 4'd0;
      step(1'b1, t, 1'b0, k >= 3, (k >= 4) && (t < tp), 1'b0,
           (k >= 4) && (t == 4'd15), (k >= 4) && (t == 4'd0), "t1_run");
    end

    // 2: injected skip while counting up, then re-acquisition
    step(1'b1, 4'd0, 1'b0, 1, 1, 0, 0, 1, "t2_valley");
    step(1'b1, 4'd1, 1'b0, 1, 0, 0, 0, 0, "t2_up");
    step(1'b1, 4'd2, 1'b0, 1, 0, 0, 0, 0, "t2_up");
    step(1'b1, 4'd3, 1'b0, 1, 0, 0, 0, 0, "t2_up");
    step(1'b1, 4'd5, 1'b0, 0, 0, 1, 0, 0, "t2_skip_err");
    step(1'b1, 4'd6, 1'b0, 0, 0, 0, 0, 0, "t2_acq");
    step(1'b1, 4'd7, 1'b0, 0, 0, 0, 0, 0, "t2_acq");
    step(1'b1, 4'd8, 1'b0, 1, 0, 0, 0, 0, "t2_relock");

    // 3/4: turnarounds, valid gap, then 15->0 wrap error
    for (int v = 9; v <= 14; v++) step(1'b1, 4'(v), 1'b0, 1, 0, 0, 0, 0, "t3_up");
    step(1'b1, 4'd15, 1'b0, 1, 0, 0, 1, 0, "t3_peak");
    step(1'b1, 4'd14, 1'b0, 1, 1, 0, 0, 0, "t3_turn_down");
    for (int v = 13; v >= 1; v--) step(1'b1, 4'(v), 1'b0, 1, 1, 0, 0, 0, "t3_down");
    step(1'b1, 4'd0, 1'b0, 1, 1, 0, 0, 1, "t3_valley");
    step(1'b1, 4'd1, 1'b0, 1, 0, 0, 0, 0, "t3_turn_up");
    for (int v = 2; v <= 7; v++) step(1'b1, 4'(v), 1'b0, 1, 0, 0, 0, 0, "t4_up");
    repeat (10) step(1'b0, 4'hA, 1'b0, 1, 0, 0, 0, 0, "t4_gap_hold");
    step(1'b1, 4'd8, 1'b0, 1, 0, 0, 0, 0, "t4_resume");
    for (int v = 9; v <= 14; v++) step(1'b1, 4'(v), 1'b0, 1, 0, 0, 0, 0, "t3_up2");
    step(1'b1, 4'd15, 1'b0, 1, 0, 0, 1, 0, "t3_peak2");
    step(1'b1, 4'd0, 1'b0, 0, 0, 1, 0, 0, "t3_wrap_err");

    // 5: repeated errors saturate the narrow counter; clear behaviour
    step(1'b1, 4'd1, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd2, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd3, 1'b0, 1, 0, 0, 0, 0, "t5_lock");
    step(1'b1, 4'd9, 1'b0, 0, 0, 1, 0, 0, "t5_err3");
    step(1'b1, 4'd10, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd11, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd12, 1'b0, 1, 0, 0, 0, 0, "t5_lock");
    step(1'b1, 4'd1, 1'b0, 0, 0, 1, 0, 0, "t5_err4_sat");
    step(1'b1, 4'd2, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd3, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd4, 1'b0, 1, 0, 0, 0, 0, "t5_lock");
    step(1'b1, 4'd0, 1'b0, 0, 0, 1, 0, 0, "t5_err5_sat");
    step(1'b1, 4'd1, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd2, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd3, 1'b0, 1, 0, 0, 0, 0, "t5_lock");
    step(1'b1, 4'd4, 1'b1, 1, 0, 0, 0, 0, "t5_clr");
    step(1'b1, 4'd9, 1'b1, 0, 0, 1, 0, 0, "t5_clr_with_err");
    step(1'b1, 4'd10, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd11, 1'b0, 0, 0, 0, 0, 0, "t5_acq");
    step(1'b1, 4'd12, 1'b0, 1, 0, 0, 0, 0, "t5_lock");
    step(1'b1, 4'd13, 1'b0, 1, 0, 0, 0, 0, "t5_up");
    step(1'b1, 4'd14, 1'b0, 1, 0, 0, 0, 0, "t5_up");
    step(1'b1, 4'd15, 1'b0, 1, 0, 0, 1, 0, "t5_peak");
    step(1'b1, 4'd14, 1'b0, 1, 1, 0, 0, 0, "t5_down");

    // 6: asynchronous reset between edges while locked
    valid = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_async_reset", actual_vec(), 20'd0);
    #1;
    rst = 1'b0;
    e8  = 8'd0;
    e2  = 2'd0;
    @(posedge clk);
    #1;
    step(1'b1, 4'd5, 1'b0, 0, 0, 0, 0, 0, "t6_search");
    step(1'b1, 4'd6, 1'b0, 0, 0, 0, 0, 0, "t6_acq");
    step(1'b1, 4'd7, 1'b0, 0, 0, 0, 0, 0, "t6_acq");
    step(1'b1, 4'd8, 1'b0, 1, 0, 0, 0, 0, "t6_relock");
    valid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
